// File: rtl/fragment_hazard_scheduler.sv
// Purpose: issues fragments to a fixed-latency pixel pipeline, holding any fragment whose framebuffer index is still in flight.
// Latency: 1 cycle from s_axis accept to m_axis valid; a same-index successor is accepted SCOREBOARD_DEPTH+2 cycles later.
// Backpressure: s_axis_tready drops on a hazard, on a full output register, or while a flush drains the pipeline.
//
// Ports:
//   aclk, resetn          clock, asynchronous active-low reset
//   s_axis_t*             fragment stream in (valid/ready, tlast, tdata)
//   m_axis_t*             fragment stream out to the pixel pipeline
//   flush_req/flush_done  drain request in, single-cycle "pipeline empty" pulse out
//   busy                  a fragment is held in the output register or in flight
// Optional: define FRAGMENT_HAZARD_STATS_EN to add the 32-bit saturating output hazard_stall_cycles.
module fragment_hazard_scheduler #(
    parameter int DATA_WIDTH              = 256,
    parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int INDEX_POS               = 0,
    parameter int SCOREBOARD_DEPTH        = 24
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  busy
`ifdef FRAGMENT_HAZARD_STATS_EN
    ,
    output logic [31:0]           hazard_stall_cycles
`endif
);

    localparam int IW = FRAMEBUFFER_INDEX_WIDTH;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_flush_done;
    logic                  r_m_vld;
    logic                  r_m_last;
    logic [DATA_WIDTH-1:0] r_m_dat;
    logic [SCOREBOARD_DEPTH-1:0] r_sb_vld;
    logic [IW-1:0]         r_sb_idx [SCOREBOARD_DEPTH];

    logic [IW-1:0]         w_s_idx;
    logic [IW-1:0]         w_m_idx;
    logic                  w_hazard;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_inflight;

    assign w_s_idx    = s_axis_tdata[INDEX_POS +: IW];
    assign w_m_idx    = r_m_dat[INDEX_POS +: IW];
    assign w_issue    = r_m_vld && m_axis_tready;
    assign w_accept   = s_axis_tvalid && s_axis_tready;
    assign w_inflight = |r_sb_vld;

    // The fragment sitting in the output register counts as in flight too,
    // so an accept that coincides with its issue is still hazard-checked.
    always_comb begin
        w_hazard = r_m_vld && (w_m_idx == w_s_idx);
        for (int i = 0; i < SCOREBOARD_DEPTH; i++) begin
            if (r_sb_vld[i] && (r_sb_idx[i] == w_s_idx)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign s_axis_tready = (r_state == ST_RUN) && !w_hazard && (!r_m_vld || m_axis_tready);
    assign m_axis_tvalid = r_m_vld;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tdata  = r_m_dat;
    assign flush_done    = r_flush_done;
    assign busy          = r_m_vld || w_inflight;

    // Output register: load on accept, clear on issue, otherwise hold.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_m_vld  <= 1'b0;
            r_m_last <= 1'b0;
            r_m_dat  <= '0;
        end else if (w_accept) begin
            r_m_vld  <= 1'b1;
            r_m_last <= s_axis_tlast;
            r_m_dat  <= s_axis_tdata;
        end else if (w_issue) begin
            r_m_vld  <= 1'b0;
        end
    end

    // Scoreboard mirrors the pipeline: shifts every cycle, oldest entry retires.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_sb_vld <= '0;
            for (int i = 0; i < SCOREBOARD_DEPTH; i++) begin
                r_sb_idx[i] <= '0;
            end
        end else begin
            r_sb_vld    <= {r_sb_vld[SCOREBOARD_DEPTH-2:0], w_issue};
            r_sb_idx[0] <= w_m_idx;
            for (int i = 1; i < SCOREBOARD_DEPTH; i++) begin
                r_sb_idx[i] <= r_sb_idx[i-1];
            end
        end
    end

    // Flush FSM; flush_done is registered and high only while in DONE.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_RUN;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (flush_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_m_vld && !w_inflight) begin
                        r_state      <= ST_DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FRAGMENT_HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall             = s_axis_tvalid && w_hazard && (r_state == ST_RUN);
    assign hazard_stall_cycles = r_stall_cnt;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fragment_hazard_scheduler.sv
// Purpose: directed stimulus with a scoreboard queue checked by an independent m_axis monitor.
// Latency: expectations carry the cycle in which each fragment should issue (or -1 when stalled).
// Backpressure: m_axis_tready is driven by the stimulus to exercise holds and flushes.
module tb_fragment_hazard_scheduler;

    localparam int DW    = 256;
    localparam int DEPTH = 24;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          flush_req;
    logic          flush_done;
    logic          busy;
`ifdef FRAGMENT_HAZARD_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    fragment_hazard_scheduler #(
        .DATA_WIDTH(DW), .FRAMEBUFFER_INDEX_WIDTH(14), .INDEX_POS(0), .SCOREBOARD_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
`ifdef FRAGMENT_HAZARD_STATS_EN
        , .hazard_stall_cycles(stall_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            c;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   flush_cnt = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic logic [DW-1:0] mk(input logic [13:0] idx, input logic [31:0] tag);
        logic [DW-1:0] d;
        d       = {8{tag}};
        d[13:0] = idx;
        return d;
    endfunction

    // Monitor: every issue must match the head of the expectation queue.
    always @(negedge aclk) begin
        exp_t e;
        if (flush_done) flush_cnt++;
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_issue");
            end else begin
                e = exp_q.pop_front();
                check("issue_data", m_axis_tdata, e.d);
                check("issue_last", DW'(m_axis_tlast), DW'(e.l));
                if (e.c >= 0) check("issue_cycle", DW'(cyc), DW'(e.c));
            end
        end
    end

    // Present a fragment and wait for its acceptance; returns with tvalid still high.
    task automatic send(input logic [DW-1:0] d, input logic l, input bit chk_cyc, output int acc);
        exp_t e;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            timeout("accept");
        end else begin
            e.d = d;
            e.l = l;
            e.c = chk_cyc ? acc + 1 : -1;
            exp_q.push_back(e);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_idle");
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [4];
        int a0, a1, acc3, rel;
        int t_idle, t_done, t_rdy, fc0;
        logic [DW-1:0] dx, dy, d2;
`ifdef FRAGMENT_HAZARD_STATS_EN
        logic [31:0] st0;
`endif
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        flush_req     = 1'b0;
        #3;
        check("rst_m_tvalid", DW'(m_axis_tvalid), '0);
        check("rst_m_tlast", DW'(m_axis_tlast), '0);
        check("rst_m_tdata", m_axis_tdata, '0);
        check("rst_flush_done", DW'(flush_done), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_s_tready", DW'(s_axis_tready), DW'(1));
        repeat (2) @(posedge aclk);
        #1;
        resetn = 1'b1;

        // 1: distinct indices stream with no bubbles
        for (int i = 0; i < 4; i++) begin
            send(mk(14'(i), 32'hA5A5_0000 + i), (i == 3), 1'b1, acc[i]);
        end
        s_axis_tvalid = 1'b0;
        for (int i = 1; i < 4; i++) check("t1_back_to_back", DW'(acc[i] - acc[0]), DW'(i));

        // 2: same index back to back waits out the pipeline
        wait_idle();
`ifdef FRAGMENT_HAZARD_STATS_EN
        st0 = stall_cnt;
`endif
        send(mk(14'h0123, 32'h1111_2222), 1'b0, 1'b1, a0);
        send(mk(14'h0123, 32'h3333_4444), 1'b1, 1'b1, a1);
        s_axis_tvalid = 1'b0;
        check("t2_hazard_spacing", DW'(a1 - a0), DW'(DEPTH + 2));
`ifdef FRAGMENT_HAZARD_STATS_EN
        check("t2_stall_cycles", DW'(stall_cnt - st0), DW'(25));
`endif

        // 3: bits above the index field are ignored by the compare
        wait_idle();
        d2 = mk(14'd5, 32'h0);
        send(d2, 1'b0, 1'b1, a0);
        d2[14] = ~d2[14];
        send(d2, 1'b0, 1'b1, a1);
        s_axis_tvalid = 1'b0;
        check("t3_upper_bits_ignored", DW'(a1 - a0), DW'(DEPTH + 2));

        // 4: downstream stall holds output and blocks input
        wait_idle();
        m_axis_tready = 1'b0;
        dx = mk(14'd10, 32'hDEAD_BEEF);
        dy = mk(14'd11, 32'hCAFE_F00D);
        send(dx, 1'b1, 1'b0, a0);
        s_axis_tdata = dy;
        s_axis_tlast = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check("t4_hold_tvalid", DW'(m_axis_tvalid), DW'(1));
            check("t4_hold_tdata", m_axis_tdata, dx);
            check("t4_hold_tlast", DW'(m_axis_tlast), DW'(1));
            check("t4_s_tready_low", DW'(s_axis_tready), '0);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        send(dy, 1'b0, 1'b1, a1);
        s_axis_tvalid = 1'b0;

        // 5: flush with three fragments in flight
        wait_idle();
        for (int i = 0; i < 3; i++) send(mk(14'(20 + i), 32'h5555_0000 + i), 1'b0, 1'b1, acc3);
        s_axis_tvalid = 1'b0;
        flush_req     = 1'b1;
        @(posedge aclk);
        #1;
        flush_req = 1'b0;
        fc0 = flush_cnt;
        t_idle = -1;
        t_done = -1;
        t_rdy  = -1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = mk(14'd30, 32'h7777_8888);
        s_axis_tlast  = 1'b1;
        @(negedge aclk);
        check("t5_drain_blocks", DW'(s_axis_tready), '0);
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (!busy && t_idle < 0) t_idle = cyc;
            if (flush_done && t_done < 0) t_done = cyc;
            flush_req = (i == 3);
            if (s_axis_tready) begin
                t_rdy = cyc;
                break;
            end
        end
        flush_req = 1'b0;
        if (t_rdy < 0) begin
            timeout("t5_resume");
        end else begin
            exp_t e;
            e.d = s_axis_tdata;
            e.l = 1'b1;
            e.c = t_rdy + 1;
            exp_q.push_back(e);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        check("t5_busy_fall", DW'(t_idle), DW'(acc3 + DEPTH + 2));
        check("t5_done_cycle", DW'(t_done), DW'(t_idle + 1));
        check("t5_resume_cycle", DW'(t_rdy), DW'(t_idle + 2));
        wait_idle();
        repeat (4) @(posedge aclk);
        #1;
        check("t5_single_pulse", DW'(flush_cnt - fc0), DW'(1));

        // 6: mid-stream reset drops in-flight state
        send(mk(14'd7, 32'h9999_AAAA), 1'b0, 1'b1, a0);
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("t6_busy_before", DW'(busy), DW'(1));
        resetn = 1'b0;
        #1;
        check("t6_rst_tvalid", DW'(m_axis_tvalid), '0);
        check("t6_rst_busy", DW'(busy), '0);
        check("t6_rst_flush_done", DW'(flush_done), '0);
        exp_q.delete();
        @(posedge aclk);
        #1;
        resetn = 1'b1;
        rel = cyc;
        send(mk(14'd7, 32'hBBBB_CCCC), 1'b1, 1'b1, a1);
        s_axis_tvalid = 1'b0;
        check("t6_accept_after_reset", DW'(a1), DW'(rel));

        wait_idle();
        repeat (2) @(posedge aclk);
        check("queue_drained", DW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
